// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      ORR = 3'b011,
      MUL = 3'b100,
      MOV = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the requester that did not win last time wins a tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       gnt_id
);

   logic last;

   always_comb begin
      gnt_id = (valid == 2'b11) ? ~last : valid[1];
      grant  = '0;
      if (valid != 2'b00)
         grant = gnt_id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         last <= 1'b1;
      else if (accept)
         last <= gnt_id;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters with round-robin grant and a held response.
// ALU_ARB_FLAGREG_EN: when defined, the architectural nzcv register is built and honours req_setf.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned N        = 16,
   parameter int unsigned MUL_WAIT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*N-1:0] req_a,
   input  logic [2*N-1:0] req_b,
   input  logic [5:0]     req_sel,
   input  logic [1:0]     req_setf,
   output logic [1:0]     resp_valid,
   input  logic [1:0]     resp_ready,
   output logic [2*N-1:0] resp_result,
   output logic [3:0]     resp_flags,
   output logic [3:0]     nzcv,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   output logic [2:0]     alu_sel,
   input  logic [2*N-1:0] alu_result,
   input  logic [3:0]     alu_flags
);

   arb_state_e state;
   logic [1:0] grant;
   logic       gnt_id;
   logic       accept;
   logic       capture;
   logic       owner;
   logic [2:0] cnt;
   logic [2:0] sel_g;

   rr_arbiter2 u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (req_valid),
      .accept (accept),
      .grant  (grant),
      .gnt_id (gnt_id)
   );

   // Ready is gated by reset so nothing is offered while rst_n is low.
   assign req_ready = (rst_n && state == IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign capture   = (state == EXEC) && (cnt == '0);
   assign sel_g     = gnt_id ? req_sel[5:3] : req_sel[2:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         cnt         <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= '0;
         resp_valid  <= '0;
         resp_result <= '0;
         resp_flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a   <= gnt_id ? req_a[2*N-1:N] : req_a[N-1:0];
                  alu_b   <= gnt_id ? req_b[2*N-1:N] : req_b[N-1:0];
                  alu_sel <= sel_g;
                  owner   <= gnt_id;
                  cnt     <= (sel_g == 3'(MUL)) ? 3'(MUL_WAIT) : '0;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  resp_result <= alu_result;
                  resp_flags  <= alu_flags;
                  resp_valid  <= owner ? 2'b10 : 2'b01;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[owner]) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_FLAGREG_EN
   logic       setf_q;
   logic [3:0] nzcv_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         setf_q <= 1'b0;
         nzcv_q <= '0;
      end else begin
         if (accept)
            setf_q <= req_setf[gnt_id];
         if (capture && setf_q)
            nzcv_q <= alu_flags;
      end
   end

   assign nzcv = nzcv_q;
`else
   logic setf_unused;
   logic capture_unused;

   assign setf_unused    = ^req_setf;
   assign capture_unused = capture;
   assign nzcv           = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural stand-in ALU and MUL_WAIT = 3.
module tb_alu_arbiter;

   localparam int unsigned N  = 16;
   localparam int unsigned MW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid, req_ready, req_setf;
   logic [2*N-1:0] req_a, req_b;
   logic [5:0]    req_sel;
   logic [1:0]    resp_valid, resp_ready;
   logic [2*N-1:0] resp_result;
   logic [3:0]    resp_flags, nzcv;
   logic [N-1:0]  alu_a, alu_b;
   logic [2:0]    alu_sel;
   logic [2*N-1:0] alu_result;
   logic [3:0]    alu_flags;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N), .MUL_WAIT(MW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_sel     (req_sel),
      .req_setf    (req_setf),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_flags  (resp_flags),
      .nzcv        (nzcv),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags)
   );

   // Stand-in ALU: flags are {N,Z,C,V}; C on SUB is the borrow out.
   logic [N:0] s;
   always_comb begin
      s          = '0;
      alu_result = '0;
      alu_flags  = '0;
      case (alu_sel)
         3'b000: begin
            s          = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = {{N{1'b0}}, s[N-1:0]};
            alu_flags  = {s[N-1], (s[N-1:0] == '0), s[N],
                          (alu_a[N-1] == alu_b[N-1]) && (s[N-1] != alu_a[N-1])};
         end
         3'b001: begin
            s          = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result = {{N{1'b0}}, s[N-1:0]};
            alu_flags  = {s[N-1], (s[N-1:0] == '0), s[N],
                          (alu_a[N-1] != alu_b[N-1]) && (s[N-1] != alu_a[N-1])};
         end
         3'b010, 3'b011, 3'b101: begin
            if (alu_sel == 3'b010)      s = {1'b0, alu_a & alu_b};
            else if (alu_sel == 3'b011) s = {1'b0, alu_a | alu_b};
            else                        s = {1'b0, alu_b};
            alu_result = {{N{1'b0}}, s[N-1:0]};
            alu_flags  = {s[N-1], (s[N-1:0] == '0), 2'b00};
         end
         3'b100: begin
            alu_result = (2*N)'(alu_a) * (2*N)'(alu_b);
            alu_flags  = {alu_result[2*N-1], (alu_result == '0), 2'b00};
         end
         default: ;
      endcase
   end

   typedef struct {
      logic [1:0]  own;
      logic [31:0] res;
      logic [3:0]  fl;
      logic [3:0]  nz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb_q[$];
   exp_t pend[2];
   exp_t ein, eout;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rise = 0;
   logic [1:0] prev_v = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] nzx(input logic [3:0] v);
`ifdef ALU_ARB_FLAGREG_EN
      return v;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Request side: push the pending expectation at each handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int r = 0; r < 2; r++) begin
            if (req_valid[r] && req_ready[r]) begin
               ein     = pend[r];
               ein.acc = cyc;
               sb_q.push_back(ein);
               chk("req_ready_onehot", {30'b0, req_ready}, {30'b0, 2'(1 << r)});
            end
         end
      end
   end

   // Response side: pop and compare when a response handshake is seen.
   always @(negedge clk) begin
      if (resp_valid != 2'b00 && prev_v == 2'b00) rise = cyc;
      prev_v = resp_valid;
      if ((resp_valid & resp_ready) != 2'b00) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid %b, expected no response", resp_valid);
         end else begin
            eout = sb_q.pop_front();
            chk("resp_valid",  {30'b0, resp_valid}, {30'b0, eout.own});
            chk("resp_result", resp_result, eout.res);
            chk("resp_flags",  {28'b0, resp_flags}, {28'b0, eout.fl});
            chk("nzcv",        {28'b0, nzcv}, {28'b0, eout.nz});
            chk("latency",     32'(rise - eout.acc), 32'(eout.lat));
         end
      end
   end

   task automatic issue(input int r, input logic [2:0] sel, input logic [15:0] a,
                        input logic [15:0] b, input logic sf, input logic [31:0] res,
                        input logic [3:0] fl, input logic [3:0] nz);
      pend[r].own = 2'(1 << r);
      pend[r].res = res;
      pend[r].fl  = fl;
      pend[r].nz  = nzx(nz);
      pend[r].lat = (sel == 3'b100) ? 2 + int'(MW) : 2;
      pend[r].acc = 0;
      req_a[r*16 +: 16] = a;
      req_b[r*16 +: 16] = b;
      req_sel[r*3 +: 3] = sel;
      req_setf[r]       = sf;
      req_valid[r]      = 1'b1;
   endtask

   task automatic wait_accept(input int r);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (req_valid[r] && req_ready[r]) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout_r%0d: req_ready=%b, expected grant", r, req_ready);
         req_valid[r] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         req_valid[r] = 1'b0;
      end
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_sel    = '0;
      req_setf   = '0;
      resp_ready = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      req_valid = 2'b01;
      @(negedge clk);
      chk("rst_req_ready",   {30'b0, req_ready}, 32'h0);
      chk("rst_resp_valid",  {30'b0, resp_valid}, 32'h0);
      chk("rst_resp_result", resp_result, 32'h0);
      chk("rst_resp_flags",  {28'b0, resp_flags}, 32'h0);
      chk("rst_nzcv",        {28'b0, nzcv}, 32'h0);
      chk("rst_alu_sel",     {29'b0, alu_sel}, 32'h0);
      chk("rst_alu_a",       {16'b0, alu_a}, 32'h0);
      chk("rst_alu_b",       {16'b0, alu_b}, 32'h0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Tie after reset: r0 first, then r1.
      issue(0, 3'b001, 16'h0005, 16'h0005, 1'b1, 32'h0000_0000, 4'b0100, 4'b0100);
      issue(1, 3'b101, 16'h1234, 16'h8000, 1'b1, 32'h0000_8000, 4'b1000, 4'b1000);
      fork
         wait_accept(0);
         wait_accept(1);
      join
      wait_drain();

      issue(0, 3'b000, 16'h0005, 16'h0003, 1'b1, 32'h0000_0008, 4'b0000, 4'b0000);
      wait_accept(0);
      wait_drain();

      issue(1, 3'b100, 16'h0010, 16'h0010, 1'b1, 32'h0000_0100, 4'b0000, 4'b0000);
      wait_accept(1);
      wait_drain();

      issue(0, 3'b001, 16'h0007, 16'h0007, 1'b1, 32'h0000_0000, 4'b0100, 4'b0100);
      wait_accept(0);
      wait_drain();
      issue(0, 3'b010, 16'h8000, 16'hFFFF, 1'b0, 32'h0000_8000, 4'b1000, 4'b0100);
      wait_accept(0);
      wait_drain();

      // Owner stalls the response; r1 waits, non-owner ready is ignored.
      resp_ready = 2'b10;
      issue(0, 3'b011, 16'h00F0, 16'h000F, 1'b1, 32'h0000_00FF, 4'b0000, 4'b0000);
      wait_accept(0);
      issue(1, 3'b000, 16'h7FFF, 16'h0001, 1'b1, 32'h0000_8000, 4'b1001, 4'b1001);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (resp_valid == 2'b01) seen = 1;
      end
      chk("stall_resp_seen", {31'b0, seen}, 32'h1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_resp_valid",  {30'b0, resp_valid}, 32'h1);
         chk("stall_resp_result", resp_result, 32'h0000_00FF);
         chk("stall_req_ready1",  {31'b0, req_ready[1]}, 32'h0);
      end
      @(posedge clk);
      #1;
      resp_ready = 2'b11;
      wait_accept(1);
      wait_drain();

      issue(1, 3'b110, 16'h0001, 16'h0002, 1'b0, 32'h0000_0000, 4'b0000, 4'b1001);
      wait_accept(1);
      chk("exec_alu_sel", {29'b0, alu_sel}, 32'h6);
      chk("exec_alu_a",   {16'b0, alu_a}, 32'h1);
      chk("exec_alu_b",   {16'b0, alu_b}, 32'h2);
      wait_drain();

      // Reset during EXEC drops the operation.
      issue(0, 3'b000, 16'h7FFF, 16'h0001, 1'b1, 32'h0000_8000, 4'b1001, 4'b1001);
      wait_accept(0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb_q.delete();
      chk("midrst_resp_valid", {30'b0, resp_valid}, 32'h0);
      chk("midrst_nzcv",       {28'b0, nzcv}, 32'h0);
      chk("midrst_alu_a",      {16'b0, alu_a}, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("midrst_no_resp", {30'b0, resp_valid}, 32'h0);
      end
      @(posedge clk);
      #1;

      // Pointer is back at 1 after reset, so r0 wins the tie again.
      issue(0, 3'b000, 16'h0002, 16'h0003, 1'b1, 32'h0000_0005, 4'b0000, 4'b0000);
      issue(1, 3'b011, 16'h0001, 16'h0002, 1'b1, 32'h0000_0003, 4'b0000, 4'b0000);
      fork
         wait_accept(0);
         wait_accept(1);
      join
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
